// File: rtl/mdu_pkg.sv
// ------------------------------------------------------------------
// mdu_pkg : op encodings, default cycle counts and FSM state type
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int DEF_MULT_CYC = 5;
  localparam int DEF_DIV_CYC  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ------------------------------------------------------------------
// mdu_arith : combinational 64-bit product and quotient/remainder
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);

  logic        w_sgn;
  logic [63:0] w_ea, w_eb, w_prod;
  logic [31:0] w_ua, w_ub, w_dvs, w_qm, w_rm, w_q, w_r;

  always_comb begin
    w_sgn      = (op_i == MD_MULT) || (op_i == MD_DIV);
    w_ea       = {{32{w_sgn & a_i[31]}}, a_i};
    w_eb       = {{32{w_sgn & b_i[31]}}, b_i};
    w_prod     = w_ea * w_eb;
    // Divide on magnitudes so 0x80000000 / -1 stays well defined.
    w_ua       = (w_sgn && a_i[31]) ? (~a_i + 32'd1) : a_i;
    w_ub       = (w_sgn && b_i[31]) ? (~b_i + 32'd1) : b_i;
    div_zero_o = (b_i == 32'd0);
    w_dvs      = div_zero_o ? 32'd1 : w_ub;
    w_qm       = w_ua / w_dvs;
    w_rm       = w_ua % w_dvs;
    w_q        = (w_sgn && (a_i[31] ^ b_i[31])) ? (~w_qm + 32'd1) : w_qm;
    w_r        = (w_sgn && a_i[31]) ? (~w_rm + 32'd1) : w_rm;
    if (is_div(op_i)) begin
      hi_o = w_r;
      lo_o = w_q;
    end else begin
      hi_o = w_prod[63:32];
      lo_o = w_prod[31:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mdu.sv
// ------------------------------------------------------------------
// mdu : multi-cycle multiply/divide unit with HI/LO registers
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYC = DEF_MULT_CYC,
  parameter int DIV_CYC  = DEF_DIV_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] c_mult_cnt = 4'(MULT_CYC);
  localparam logic [3:0] c_div_cnt  = 4'(DIV_CYC);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic [31:0] hi_d, lo_d;
  logic        div_zero;

  mdu_arith u_arith (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .hi_o       (hi_d),
    .lo_o       (lo_d),
    .div_zero_o (div_zero)
  );

  assign busy  = (state_q == ST_RUN);
  assign stall = start & busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                op_q    <= op;
                a_q     <= a;
                b_q     <= b;
                cnt_q   <= is_div(op) ? c_div_cnt : c_mult_cnt;
                state_q <= ST_RUN;
              end
              MD_MTHI: hi_q <= a;
              MD_MTLO: lo_q <= a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cnt_q == 4'd1) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            // Division by zero burns the full period but keeps HI/LO.
            if (!(is_div(op_q) && div_zero)) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The module SHALL have parameter MULT_CYC, default 5, meaning busy-cycle count for MULT/MULTU (legal 1..15).
REQ-002 The module SHALL have parameter DIV_CYC, default 10, meaning busy-cycle count for DIV/DIVU (legal 1..15).
REQ-003 Port clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request valid; op/a/b are qualified by it.
REQ-006 Port op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 Port a  input  32  rs operand or dividend; MTHI/MTLO source.
REQ-008 Port b  input  32  rt operand or divisor.
REQ-009 Port busy  output  1  registered; a MULT/DIV operation is in flight.
REQ-010 Port stall  output  1  combinational; equals start & busy; the request is rejected this cycle.
REQ-011 Port hi  output  32  registered HI.
REQ-012 Port lo  output  32  registered LO.

Function
REQ-013 A request SHALL be accepted at a rising edge where start=1 and busy=0; when busy=1 it SHALL be ignored and stall=1, with the requester holding op/a/b until stall falls.
REQ-014 On acceptance of ops 0-3, a, b and op SHALL be latched, the counter loaded with MULT_CYC or DIV_CYC, and busy SHALL be 1 from the next cycle.
REQ-015 FSM states: IDLE (busy=0) and RUN (busy=1); IDLE->RUN on accepted op 0-3; RUN->IDLE at the edge where the counter equals 1; the counter decrements on every other RUN edge.
REQ-016 busy SHALL be high for exactly N cycles (N = MULT_CYC or DIV_CYC); hi/lo SHALL update at the same edge busy falls, and no earlier.
REQ-017 A request presented in the first cycle after busy falls SHALL be accepted, giving back-to-back throughput of N+1 cycles per operation.
REQ-018 MULT SHALL produce the signed 64-bit product and MULTU the unsigned 64-bit product, with {hi,lo} = product.
REQ-019 DIV/DIVU SHALL set lo = quotient and hi = remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-021 A divisor of 0 SHALL run the full DIV_CYC busy period and leave hi/lo unchanged.
REQ-022 MTHI/MTLO SHALL write a to hi/lo at the accept edge, with no busy period; if busy=1 they SHALL be rejected via stall like any other op.
REQ-023 Ops 6-7 SHALL be accepted as no-ops: no state change and no busy.
REQ-024 Operand inputs SHALL be ignored while busy; results SHALL depend only on the latched values.

Reset
REQ-025 reset=0 SHALL immediately force hi=0, lo=0, busy=0, counter=0 and state IDLE, independent of clk.
REQ-026 Reset during RUN SHALL discard the in-flight result; the first edge after release with start=1 SHALL be accepted.
REQ-027 stall SHALL be 0 whenever reset=0.

Structure
REQ-028 Package mdu_pkg SHALL hold the op encodings (MD_MULT..MD_MTLO) and the default cycle constants; the module and benches SHALL import it.
REQ-029 The 64-bit product and quotient/remainder SHALL be computed in one combinational sub-module, mdu_arith, fed from the latched operands; mdu holds the FSM, counter and HI/LO registers.
REQ-030 The counter SHALL be 4 bits wide.

Verification
REQ-031 MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 DIV a=-7, b=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU a=7, b=0 -> busy 10 cycles; hi/lo unchanged.
REQ-034 MULT accepted, MTLO a=0x1234 held with start=1 during busy -> stall=1 for 5 cycles, accepted in the cycle after busy falls; lo=0x1234 and hi equals the product's high word.
REQ-035 DIV started, reset pulsed low at busy cycle 4 -> hi=lo=0 and busy=0 immediately; MTHI a=0xA5A5A5A5 after release -> hi=0xA5A5A5A5 at that edge.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, with no simulation X on any output.
